// File: rtl/light_pkg.sv
// Shared constants and types for the corridor light usage monitor.
package light_pkg;

    localparam int unsigned NCH = 3;

    // Readout selector encodings
    localparam logic [1:0] SEL_CH0   = 2'd0;
    localparam logic [1:0] SEL_CH1   = 2'd1;
    localparam logic [1:0] SEL_CH2   = 2'd2;
    localparam logic [1:0] SEL_FAULT = 2'd3;

    // Readout handshake states
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rd_state_e;

    localparam int unsigned DEF_TICKS_PER_SEC = 10;
    localparam int unsigned DEF_OFF_TIMEOUT   = 100;
    localparam int unsigned DEF_SEC_W         = 16;
    localparam int unsigned DEF_EVT_W         = 8;

endpackage

// File: rtl/light_chan_meter.sv
// Per-lamp meter: on-time seconds, switch-on events and empty-zone fault.
module light_chan_meter
    import light_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int unsigned OFF_TIMEOUT   = DEF_OFF_TIMEOUT,
    parameter int unsigned SEC_W         = DEF_SEC_W,
    parameter int unsigned EVT_W         = DEF_EVT_W
) (
    input  logic             clk10,
    input  logic             rst,
    input  logic             light_n,
    input  logic             switch_n,
    input  logic             clr,
    input  logic             fault_clr,
    output logic [SEC_W-1:0] sec,
    output logic [EVT_W-1:0] evt,
    output logic             fault_n
);

    localparam int unsigned PS_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned EMP_W = $clog2(OFF_TIMEOUT + 1);
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [EMP_W-1:0] EMP_MAX = EMP_W'(OFF_TIMEOUT);

    logic [PS_W-1:0]  ps_q, ps_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic [EMP_W-1:0] emp_q, emp_d;
    logic             light_q, light_d;
    logic             fault_q, fault_d;
    logic             wrap;

    // Next-state for all counters; a clear on this cycle overrides any increment.
    always_comb begin
        ps_d    = ps_q;
        sec_d   = sec_q;
        evt_d   = evt_q;
        emp_d   = emp_q;
        fault_d = fault_q;
        light_d = light_n;
        wrap    = light_n && (ps_q == PS_MAX);

        // Prescaler holds while dark so partial seconds carry over
        if (light_n) begin
            ps_d = wrap ? '0 : ps_q + PS_W'(1);
        end
        if (wrap && (sec_q != '1)) begin
            sec_d = sec_q + SEC_W'(1);
        end

        if (light_n && !light_q && (evt_q != '1)) begin
            evt_d = evt_q + EVT_W'(1);
        end

        if (light_n && !switch_n) begin
            emp_d = (emp_q == EMP_MAX) ? emp_q : emp_q + EMP_W'(1);
        end else begin
            emp_d = '0;
        end
        if (emp_d == EMP_MAX) begin
            fault_d = 1'b1;
        end

        if (clr) begin
            ps_d  = '0;
            sec_d = '0;
            evt_d = '0;
        end
        if (fault_clr) begin
            fault_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk10 or negedge rst) begin
        if (!rst) begin
            ps_q    <= '0;
            sec_q   <= '0;
            evt_q   <= '0;
            emp_q   <= '0;
            light_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            sec_q   <= sec_d;
            evt_q   <= evt_d;
            emp_q   <= emp_d;
            light_q <= light_d;
            fault_q <= fault_d;
        end
    end

    assign sec     = sec_q;
    assign evt     = evt_q;
    assign fault_n = fault_q;

endmodule

// File: rtl/light_usage_monitor.sv
// Lamp usage monitor: three channel meters plus a four-phase readout port.
module light_usage_monitor
    import light_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int unsigned OFF_TIMEOUT   = DEF_OFF_TIMEOUT,
    parameter int unsigned SEC_W         = DEF_SEC_W,
    parameter int unsigned EVT_W         = DEF_EVT_W
) (
    input  logic                     clk10,
    input  logic                     rst,
    input  logic [NCH-1:0]           switch,
    input  logic [NCH-1:0]           light,
    input  logic                     rd_req,
    input  logic [1:0]               rd_sel,
    input  logic                     rd_clr,
    output logic                     rd_valid,
    output logic [EVT_W+SEC_W-1:0]   rd_data,
    output logic [NCH-1:0]           fault
);

    localparam int unsigned DATA_W = EVT_W + SEC_W;

    rd_state_e         state_q, state_d;
    logic              wait_low_q, wait_low_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mux_word;
    logic              capture;
    logic [NCH-1:0]    chan_clr;
    logic              fault_clr;
    logic [SEC_W-1:0]  sec_w [NCH];
    logic [EVT_W-1:0]  evt_w [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        light_chan_meter #(
            .TICKS_PER_SEC (TICKS_PER_SEC),
            .OFF_TIMEOUT   (OFF_TIMEOUT),
            .SEC_W         (SEC_W),
            .EVT_W         (EVT_W)
        ) u_meter (
            .clk10     (clk10),
            .rst       (rst),
            .light_n   (light[i]),
            .switch_n  (switch[i]),
            .clr       (chan_clr[i]),
            .fault_clr (fault_clr),
            .sec       (sec_w[i]),
            .evt       (evt_w[i]),
            .fault_n   (fault[i])
        );
    end

    // Response word selection, sampled only on the capture cycle
    always_comb begin
        mux_word = '0;
        case (rd_sel)
            SEL_CH0:   mux_word = {evt_w[0], sec_w[0]};
            SEL_CH1:   mux_word = {evt_w[1], sec_w[1]};
            SEL_CH2:   mux_word = {evt_w[2], sec_w[2]};
            SEL_FAULT: mux_word = {{(DATA_W - NCH){1'b0}}, fault};
            default:   mux_word = '0;
        endcase
    end

    // Readout FSM next-state; after reset the host must drop rd_req once before service
    always_comb begin
        state_d    = state_q;
        wait_low_d = wait_low_q;
        data_d     = data_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (wait_low_q) begin
                    if (!rd_req) begin
                        wait_low_d = 1'b0;
                    end
                end else if (rd_req) begin
                    capture = 1'b1;
                    data_d  = mux_word;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!rd_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear strobes fire on the capture cycle only
    always_comb begin
        chan_clr = '0;
        for (int i = 0; i < NCH; i++) begin
            chan_clr[i] = capture && rd_clr && (rd_sel == 2'(i));
        end
        fault_clr = capture && rd_clr && (rd_sel == SEL_FAULT);
    end

    // Readout state registers
    always_ff @(posedge clk10 or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_low_q <= 1'b1;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_low_q <= wait_low_d;
            data_q     <= data_d;
        end
    end

    assign rd_valid = (state_q == RESP);
    assign rd_data  = data_q;

endmodule

// File: tb/tb_light_usage_monitor.sv
// Self-checking bench for light_usage_monitor against an on-time/event model.
module tb_light_usage_monitor;

    localparam int T  = 10;
    localparam int OT = 100;

    logic        clk10 = 1'b0;
    logic        rst;
    logic [2:0]  switch, light;
    logic        rd_req, rd_clr;
    logic [1:0]  rd_sel;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [2:0]  fault;

    // Second instance with one tick per second for saturation runs
    logic [2:0]  s_light;
    logic [2:0]  s_switch;
    logic        s_req, s_clr;
    logic [1:0]  s_sel;
    logic        s_valid;
    logic [23:0] s_data;
    logic [2:0]  s_fault;

    int checks   = 0;
    int failures = 0;

    // Model: total on-cycles since clear, rising edges, empty run length, fault
    longint m_on   [3];
    int     m_evt  [3];
    int     m_run  [3];
    bit     m_prev [3];
    bit     m_fault[3];
    logic [23:0] exp_word;

    always #5 clk10 = ~clk10;

    light_usage_monitor u_dut (
        .clk10    (clk10),
        .rst      (rst),
        .switch   (switch),
        .light    (light),
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .rd_clr   (rd_clr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .fault    (fault)
    );

    light_usage_monitor #(
        .TICKS_PER_SEC (1)
    ) u_sat (
        .clk10    (clk10),
        .rst      (rst),
        .switch   (s_switch),
        .light    (s_light),
        .rd_req   (s_req),
        .rd_sel   (s_sel),
        .rd_clr   (s_clr),
        .rd_valid (s_valid),
        .rd_data  (s_data),
        .fault    (s_fault)
    );

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_on[n] = 0; m_evt[n] = 0; m_run[n] = 0; m_prev[n] = 0; m_fault[n] = 0;
        end
    endtask

    function automatic logic [23:0] model_word(input int sel);
        longint s;
        int e;
        if (sel == 3) return {21'b0, m_fault[2], m_fault[1], m_fault[0]};
        s = m_on[sel] / T;
        if (s > 65535) s = 65535;
        e = (m_evt[sel] > 255) ? 255 : m_evt[sel];
        return {8'(e), 16'(s)};
    endfunction

    // One clock: model consumes current inputs, then DUT edge, then settle
    task automatic tick(input bit cap = 0, input int sel = 0, input bit clr = 0);
        if (cap) exp_word = model_word(sel);
        for (int n = 0; n < 3; n++) begin
            if (light[n]) m_on[n]++;
            if (light[n] && !m_prev[n]) m_evt[n]++;
            m_prev[n] = light[n];
            if (light[n] && !switch[n]) m_run[n] = (m_run[n] < OT) ? m_run[n] + 1 : OT;
            else m_run[n] = 0;
            if (m_run[n] == OT) m_fault[n] = 1;
        end
        if (cap && clr) begin
            if (sel == 3) begin
                for (int n = 0; n < 3; n++) m_fault[n] = 0;
            end else begin
                m_on[sel] = 0;
                m_evt[sel] = 0;
            end
        end
        @(posedge clk10);
        #1;
    endtask

    task automatic read(input int sel, input bit clr, input logic [23:0] want,
                        input bit use_want, input string tag);
        rd_sel = 2'(sel);
        rd_clr = clr;
        rd_req = 1'b1;
        check({tag, "_pre_valid"}, {23'b0, rd_valid}, 24'd0);
        tick(1, sel, clr);
        check({tag, "_valid"}, {23'b0, rd_valid}, 24'd1);
        check({tag, "_model"}, rd_data, exp_word);
        if (use_want) check({tag, "_const"}, rd_data, want);
        rd_req = 1'b0;
        rd_clr = 1'b0;
        tick();
        check({tag, "_drop"}, {23'b0, rd_valid}, 24'd0);
    endtask

    task automatic sat_step();
        @(posedge clk10);
        #1;
    endtask

    task automatic sat_read(input int sel, input logic [23:0] want, input string tag);
        s_sel = 2'(sel);
        s_req = 1'b1;
        sat_step();
        check({tag, "_valid"}, {23'b0, s_valid}, 24'd1);
        check({tag, "_data"}, s_data, want);
        s_req = 1'b0;
        sat_step();
    endtask

    initial begin
        logic [23:0] held;
        rst = 1'b0;
        switch = '0; light = '0; rd_req = 0; rd_clr = 0; rd_sel = '0;
        s_light = '0; s_switch = 3'b111; s_req = 0; s_clr = 0; s_sel = '0;
        model_reset();
        exp_word = '0;
        repeat (2) @(posedge clk10);
        #1;
        check("rst_valid", {23'b0, rd_valid}, 24'd0);
        check("rst_data", rd_data, 24'd0);
        check("rst_fault", {21'b0, fault}, 24'd0);
        rst = 1'b1;
        tick();

        // On-time with partial second left in the prescaler
        light = 3'b001;
        repeat (35) tick();
        light = 3'b000;
        tick();
        read(0, 0, 24'h01_0003, 1, "ch0_35cyc");

        // Three pulses, read with clear, then re-read
        repeat (3) begin
            light[1] = 1'b1;
            repeat (4) tick();
            light[1] = 1'b0;
            repeat (2) tick();
        end
        read(1, 1, 24'h03_0001, 1, "ch1_clr");
        read(1, 0, 24'h00_0000, 1, "ch1_reread");

        // Empty-zone fault threshold
        light[2] = 1'b1;
        repeat (99) tick();
        check("fault_99", {21'b0, fault}, 24'd0);
        tick();
        check("fault_100", {21'b0, fault}, 24'd4);
        light[2] = 1'b0;
        tick();
        read(3, 1, 24'h00_0004, 1, "fault_clr");
        check("fault_after_clr", {21'b0, fault}, 24'd0);

        // Occupancy toggling every 50 cycles keeps the fault away
        light[2] = 1'b1;
        for (int seg = 0; seg < 6; seg++) begin
            switch[2] = seg[0];
            repeat (50) tick();
        end
        check("toggle_nofault", {21'b0, fault}, 24'd0);
        light = '0;
        switch = '0;
        tick();

        // Second tick on the capture cycle: clear wins
        read(0, 1, 24'h01_0003, 1, "ch0_preclr");
        light[0] = 1'b1;
        repeat (9) tick();
        read(0, 1, 24'h01_0000, 1, "ch0_tick_on_clr");
        light[0] = 1'b0;
        tick();
        read(0, 0, 24'h00_0000, 1, "ch0_after_clr");

        // Long request: later rd_sel/rd_clr changes are ignored
        light = 3'b110;
        repeat (25) tick();
        light = '0;
        rd_sel = 2'd1;
        rd_clr = 1'b0;
        rd_req = 1'b1;
        tick(1, 1, 0);
        held = exp_word;
        check("hold_first", rd_data, held);
        for (int i = 0; i < 19; i++) begin
            rd_sel = 2'($urandom);
            rd_clr = 1'($urandom);
            tick();
            check("hold_data", rd_data, held);
            check("hold_valid", {23'b0, rd_valid}, 24'd1);
        end
        rd_req = 1'b0;
        rd_clr = 1'b0;
        tick();
        check("hold_drop", {23'b0, rd_valid}, 24'd0);
        read(1, 0, 24'h00_0000, 0, "hold_noclr");

        // Reset in the middle of a response
        rd_sel = 2'd2;
        rd_req = 1'b1;
        tick(1, 2, 0);
        check("mid_valid", {23'b0, rd_valid}, 24'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {23'b0, rd_valid}, 24'd0);
        check("mid_rst_data", rd_data, 24'd0);
        model_reset();
        @(posedge clk10);
        #1;
        rst = 1'b1;
        repeat (3) begin
            tick();
            check("mid_wait_low", {23'b0, rd_valid}, 24'd0);
        end
        rd_req = 1'b0;
        tick();
        read(3, 0, 24'h00_0000, 1, "mid_reserve");

        // Random activity checked against the model
        for (int r = 0; r < 4; r++) begin
            repeat (250) begin
                if ($urandom_range(7) == 0) light = 3'($urandom);
                if ($urandom_range(15) == 0) switch = 3'($urandom);
                tick();
            end
            for (int s = 0; s < 4; s++) begin
                read(s, 1'($urandom), 24'd0, 0, "rand");
            end
            check("rand_fault", {21'b0, fault},
                  {21'b0, m_fault[2], m_fault[1], m_fault[0]});
        end
        light = '0;
        switch = '0;

        // Saturation on the one-tick-per-second instance, all lamps together
        repeat (300) begin
            s_light = 3'b111;
            sat_step();
            s_light = 3'b000;
            sat_step();
        end
        sat_read(1, 24'hFF_012C, "sat_evt");
        s_light = 3'b111;
        repeat (65300) sat_step();
        sat_read(0, 24'hFF_FFFF, "sat_ch0");
        sat_read(2, 24'hFF_FFFF, "sat_ch2");
        check("sat_fault", {21'b0, s_fault}, 24'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
